// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 code (p0 = u^s0^s1, p1 = u^s0).
// Serial code bits are paired into symbols. Each symbol runs one add-compare-select
// step over four states. Survivors are kept in register-exchange form, and one
// decision is emitted per symbol once the survivor window is full.
module viterbi_decoder #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  input  logic in_valid,
  output logic out,
  output logic out_valid
);

  localparam int                CW       = PM_W + 2;
  localparam int                CNT_W    = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0]   PM_INIT  = PM_W'(2 ** (PM_W - 2));
  localparam logic [CW-1:0]     PM_MAX   = CW'((2 ** PM_W) - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(TB_DEPTH);

  logic                phase_reg;
  logic                p0_reg;
  logic                sym_done_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [PM_W-1:0]     pm_reg    [4];
  logic [TB_DEPTH-1:0] path_reg  [4];
  logic [CW-1:0]       cand      [4];
  logic [PM_W-1:0]     pm_next   [4];
  logic [TB_DEPTH-1:0] path_next [4];
  logic [CW-1:0]       cand_min;
  logic [PM_W-1:0]     best_pm;
  logic [1:0]          best_idx;
  logic [1:0]          rx;
  logic                sym_fire;

  // The received symbol is the latched p0 followed by the bit on the input now
  assign rx       = {p0_reg, in};
  assign sym_fire = in_valid & phase_reg;

  // Add-compare-select for new state {a,b}: predecessors {b,0} and {b,1}, input bit u=a
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_acs
      localparam logic A  = 1'((gi >> 1) & 1);
      localparam logic B  = 1'(gi & 1);
      localparam int   P0 = 2 * (gi & 1);
      localparam int   P1 = P0 + 1;
      logic [1:0]    exp0;
      logic [1:0]    exp1;
      logic [CW-1:0] c0;
      logic [CW-1:0] c1;
      logic          pick1;
      // Expected pair from the predecessor whose s1 is 0 and from the one whose s1 is 1
      assign exp0  = {A ^ B, A ^ B};
      assign exp1  = {~(A ^ B), A ^ B};
      assign c0    = CW'(pm_reg[P0]) + CW'(rx[1] ^ exp0[1]) + CW'(rx[0] ^ exp0[0]);
      assign c1    = CW'(pm_reg[P1]) + CW'(rx[1] ^ exp1[1]) + CW'(rx[0] ^ exp1[0]);
      // Strict compare: ties keep the predecessor with s1 = 0
      assign pick1 = (c1 < c0);
      assign cand[gi]      = pick1 ? c1 : c0;
      assign path_next[gi] = {pick1 ? path_reg[P1][TB_DEPTH-2:0] : path_reg[P0][TB_DEPTH-2:0], A};
    end
  endgenerate

  // Smallest of the four candidate metrics, removed from all of them to bound growth
  always_comb begin
    cand_min = cand[0];
    for (int i = 1; i < 4; i++) begin
      if (cand[i] < cand_min) cand_min = cand[i];
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_norm
      logic [CW-1:0] diff;
      assign diff        = cand[gi] - cand_min;
      assign pm_next[gi] = (diff > PM_MAX) ? {PM_W{1'b1}} : diff[PM_W-1:0];
    end
  endgenerate

  // Best state on the stored metrics: lowest metric, ties go to the lowest index
  always_comb begin
    best_pm  = pm_reg[0];
    best_idx = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (pm_reg[i] < best_pm) begin
        best_pm  = pm_reg[i];
        best_idx = 2'(i);
      end
    end
  end

  // Deserializer: latch p0, then a symbol completes on the following valid bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_reg <= 1'b0;
      p0_reg    <= 1'b0;
    end else if (in_valid) begin
      if (!phase_reg) p0_reg <= in;
      phase_reg <= ~phase_reg;
    end
  end

  // Trellis state: metrics, survivor paths and the saturating symbol counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 0) pm_reg[i] <= '0;
        else        pm_reg[i] <= PM_INIT;
        path_reg[i] <= '0;
      end
      count_reg    <= '0;
      sym_done_reg <= 1'b0;
    end else begin
      sym_done_reg <= sym_fire;
      if (sym_fire) begin
        for (int i = 0; i < 4; i++) begin
          pm_reg[i]   <= pm_next[i];
          path_reg[i] <= path_next[i];
        end
        if (count_reg != CNT_FULL) count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  // Decision one clock after each symbol once the window is full; out holds between pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sym_done_reg && (count_reg == CNT_FULL)) begin
        out_valid <= 1'b1;
        out       <= path_reg[best_idx][TB_DEPTH-1];
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder. The reference is the convolutional encoder
// plus the fact that a correctable stream decodes back to its own information bits:
// symbol n's completion schedules information bit n-TB_DEPTH+1 one clock later.
module tb_viterbi_decoder;

  localparam int D = 16;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic in       = 1'b0;
  logic in_valid = 1'b0;
  logic out;
  logic out_valid;

  viterbi_decoder #(.TB_DEPTH(D), .PM_W(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic bit_v;
    int   sym;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   errors   = 0;
  int   checks   = 0;
  int   pulses   = 0;
  logic last_out = 1'b0;
  bit   mon_en   = 1'b0;

  // Session state of the reference encoder
  logic es0 = 1'b0;
  logic es1 = 1'b0;
  logic info_q[$];
  int   nsym = 0;

  logic known[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per pulse, checks bit and arrival cycle, and that out holds
  always @(negedge clock) begin
    if (mon_en && (reset === 1'b1)) begin
      if (out_valid === 1'b1) begin
        pulses++;
        if (sb.size() == 0) begin
          check("unexpected_pulse", {31'b0, out_valid}, 32'd0);
        end else begin
          e_mon = sb.pop_front();
          $display("pulse cycle=%0d sym=%0d out=%0d exp=%0d", cyc, e_mon.sym, out, e_mon.bit_v);
          check("out_bit", {31'b0, out}, {31'b0, e_mon.bit_v});
          check("pulse_cycle", cyc, e_mon.cyc);
        end
        last_out = out;
      end else begin
        check("out_valid_low", {31'b0, out_valid}, 32'd0);
        check("out_hold", {31'b0, out}, {31'b0, last_out});
      end
    end
  end

  task automatic send_bit(input logic b, input int gap);
    int g;
    g = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
    repeat (g) @(negedge clock);
    in       = b;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    in       = 1'($urandom);
  endtask

  task automatic send_symbol(input logic u, input int gap, input logic [1:0] flip);
    logic p0, p1;
    int   e;
    p0 = u ^ es0 ^ es1;
    p1 = u ^ es0;
    send_bit(p0 ^ flip[1], gap);
    send_bit(p1 ^ flip[0], gap);
    e = cyc;
    info_q.push_back(u);
    if (nsym >= D - 1) sb.push_back('{bit_v: info_q[nsym-D+1], sym: nsym - D + 1, cyc: e + 1});
    nsym++;
    es1 = es0;
    es0 = u;
  endtask

  task automatic release_reset();
    sb.delete();
    info_q.delete();
    nsym     = 0;
    es0      = 1'b0;
    es1      = 1'b0;
    last_out = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
  endtask

  // Mid-clock asynchronous reset; optionally wait for all scheduled pulses first
  task automatic do_reset(input bit drain);
    if (drain) begin
      repeat (4) @(negedge clock);
      check("missing_pulses", 32'(sb.size()), 32'd0);
    end
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("reset_out", {31'b0, out}, 32'd0);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    release_reset();
  endtask

  task automatic known_session(input int gap, input bit err);
    int p;
    p = pulses;
    for (int i = 0; i < 26; i++) begin
      send_symbol((i < 6) ? known[i] : 1'b0, gap, (err && i == 2) ? 2'b10 : 2'b00);
    end
    repeat (3) @(negedge clock);
    check("known_pulse_count", pulses - p, 32'd11);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int n;
    int gap;
    int since_err;
    logic [1:0] flip;
    known = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Power-up reset asserted mid-clock: outputs must clear at once
    #13 reset = 1'b0;
    #1;
    check("por_out", {31'b0, out}, 32'd0);
    check("por_out_valid", {31'b0, out_valid}, 32'd0);
    release_reset();
    mon_en = 1'b1;

    // No pulses while nothing is received
    p = pulses;
    repeat (30) @(negedge clock);
    check("idle_no_pulse", pulses - p, 32'd0);

    // All-zero stream: 20 symbols give 5 zero decisions
    p = pulses;
    repeat (20) send_symbol(1'b0, 0, 2'b00);
    repeat (3) @(negedge clock);
    check("zero_pulse_count", pulses - p, 32'd5);
    do_reset(1'b1);

    // Known message, clean, back-to-back
    known_session(0, 1'b0);
    do_reset(1'b1);
    // Known message with p0 of symbol 2 flipped
    known_session(0, 1'b1);
    do_reset(1'b1);
    // Known message with idle gaps between bits
    known_session(3, 1'b0);
    do_reset(1'b1);

    // Reset mid-stream between p0 and p1, then the known message again
    for (int i = 0; i < 10; i++) send_symbol(1'($urandom), 0, 2'b00);
    send_bit(1'($urandom), 0);
    do_reset(1'b0);
    p = pulses;
    repeat (20) @(negedge clock);
    check("no_stale_pulse", pulses - p, 32'd0);
    known_session(1, 1'b0);
    do_reset(1'b1);

    // Reset landing on a live pulse carrying a 1: both outputs drop asynchronously
    send_symbol(1'b1, 0, 2'b00);
    repeat (15) send_symbol(1'b0, 0, 2'b00);
    @(posedge clock);
    #1;
    check("pre_reset_valid", {31'b0, out_valid}, 32'd1);
    check("pre_reset_out", {31'b0, out}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_out", {31'b0, out}, 32'd0);
    check("async_out_valid", {31'b0, out_valid}, 32'd0);
    release_reset();

    // Random messages with gaps and widely spaced single bit errors
    for (int s = 0; s < 6; s++) begin
      n = int'($urandom_range(30, 70));
      gap = int'($urandom_range(0, 3));
      since_err = 0;
      p = pulses;
      for (int i = 0; i < n; i++) begin
        flip = 2'b00;
        since_err++;
        if (since_err >= 24 && $urandom_range(0, 4) == 0) begin
          flip = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
          since_err = 0;
        end
        send_symbol(1'($urandom), gap, flip);
      end
      repeat (3) @(negedge clock);
      check("random_pulse_count", pulses - p, n - D + 1);
      do_reset(1'b1);
    end

    repeat (5) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/viterbi_decoder.md
# viterbi_decoder

Hard-decision Viterbi decoder for the rate-1/2, constraint-length-3 convolutional code used by the PRML channel. It sits directly downstream of the convolutional encoder and the channel and consumes the serial coded stream: two code bits per information bit, p0 first, then p1. It emits one decoded information bit per received symbol after a fixed decision depth, using a register-exchange survivor memory.

## Interface
- TB_DEPTH, 16, survivor path length in symbols (decision depth), ≥ 4
- PM_W, 6, path-metric width in bits, ≥ 5
- clock  input  1  single clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- in  input  1  serial code bit, sampled when in_valid=1
- in_valid  input  1  qualifies in for one clock
- out  output  1  decoded information bit
- out_valid  output  1  one-cycle pulse qualifying out

## Operation
- Code definition: encoder state {s0,s1}, where s0 = previous info bit and s1 = the bit before it. State index = 2·s0+s1, reset state 0. Input u gives p0 = u^s0^s1, p1 = u^s0, and next state {u,s0}.
- Deserializer: phase flag, 0 after reset. On a valid bit in phase 0, latch p0 and set phase=1. On a valid bit in phase 1, form the symbol {p0,in}, run ACS, and set phase=0. in_valid=0 holds all state.
- Branch metric: Hamming distance between the received pair and the expected pair, 0..2.
- ACS, per new state {a,b}: predecessors are {b,0} and {b,1}, with u=a. Candidate = PM[pred] + BM. Select the smaller candidate; on a tie, select the predecessor with s1=0.
- Normalization: subtract the minimum of the four new metrics from all four. Saturate at 2^PM_W−1. The stored minimum is always 0.
- Path registers: one per state, TB_DEPTH bits, bit 0 = newest. New path = {chosen_pred_path[TB_DEPTH−2:0], a}.
- Initial values: PM[0]=0, PM[1..3]=2^(PM_W−2). All paths = 0.
- Symbol counter: counts completed symbols and saturates at TB_DEPTH.
- Output: best state = lowest PM, ties to the lowest index. out = path[best][TB_DEPTH−1].
- Reset, at any time including mid-symbol: phase=0, metrics and paths reinitialised, counter=0, out=0, out_valid=0. A half-received symbol is discarded.

## Timing
- Edge E = the edge that samples p1 of symbol n (n from 0). PM, paths and counter update at E.
- At E+1, out_valid=1 and out = decoded bit of symbol n−TB_DEPTH+1, if the counter reached TB_DEPTH at or before E. Otherwise out_valid stays 0.
- out_valid is high for exactly one clock per symbol. out holds its value between pulses.
- The first pulse occurs 1 clock after the p1 edge of symbol TB_DEPTH−1 and carries the bit of symbol 0.
- Back-to-back valid bits give one symbol per 2 clocks. Throughput is bounded only by in_valid.
- Reset asserted: out and out_valid go to 0 asynchronously. Sampling resumes on the first rising edge after deassertion.

## Test plan
- Reset: assert reset mid-clock → out=0 and out_valid=0 immediately; after release, no pulses while in_valid=0.
- All-zero stream, 20 symbols of 00, TB_DEPTH=16 → 5 pulses, all out=0, the first 1 clock after the p1 edge of symbol 15.
- Known message u = 1,0,1,1,0,0 followed by zeros, sent as pairs 11 11 01 00 01 10 00… → first six decoded bits 1,0,1,1,0,0, then 0s.
- Single error: same message with p0 of symbol 2 flipped (pair 11 instead of 01) → decoded bits identical to the clean case.
- Gapped input: same message with 0–3 random idle cycles between bits → identical decoded sequence; pulse positions shift by the idle count.
- Reset mid-stream: after 10 symbols, assert reset between p0 and p1, then send the known message → no stale pulses; first pulse after 16 new symbols, decoded 1,0,1,1,0,0.
